// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared FSM encodings and reset defaults for the fetch unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int unsigned C_STATE_W = 2;

    localparam logic [C_STATE_W-1:0] ST_FETCH = 2'd0;
    localparam logic [C_STATE_W-1:0] ST_WAIT  = 2'd1;
    localparam logic [C_STATE_W-1:0] ST_HOLD  = 2'd2;

    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-outstanding instruction fetcher with decoder handshake
//              and branch redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESETN,
    output logic [31:0] memory_address,
    output logic        memory_read_strobe,
    input  logic [31:0] memory_read_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] C_PC_INCR   = 32'd4;
    localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] C_RESET_PC  = RESET_PC & C_WORD_MASK;

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_next_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic [31:0]          r_instr_pc;
    logic [31:0]          r_fetch_count;
    logic                 w_transfer;
    logic [31:0]          w_redirect_word;

    assign w_transfer      = (r_state == ST_HOLD) && instr_ready;
    assign w_redirect_word = redirect_pc & C_WORD_MASK;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A redirect overrides every state, abandoning any read in flight.
    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            w_next_state = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: w_next_state = ST_WAIT;
                ST_WAIT:  w_next_state = ST_HOLD;
                ST_HOLD:  w_next_state = instr_ready ? ST_FETCH : ST_HOLD;
                default:  w_next_state = ST_FETCH;
            endcase
        end
    end

    // Strobe is gated by RESETN so it stays low while reset is held.
    always_comb begin
        memory_read_strobe = (r_state == ST_FETCH) && RESETN;
        instr_valid        = (r_state == ST_HOLD);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pc          <= C_RESET_PC;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            if (redirect_valid) begin
                r_pc <= w_redirect_word;
            end else if (w_transfer) begin
                r_pc <= r_pc + C_PC_INCR;
            end

            if ((r_state == ST_WAIT) && !redirect_valid) begin
                r_instr    <= memory_read_data;
                r_instr_pc <= r_pc;
            end

            if (w_transfer) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign memory_address = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign fetch_count    = r_fetch_count;

endmodule

`default_nettype wire
